pipelined_carry_select_adder: RTL and testbench
===============================================

// Module: pipelined_carry_select_adder
// PURPOSE
//  - Parametrised, pipelined carry-select adder/subtractor. Next generation of the team's 4-bit carry-select adder.
//  - Operands split into BLK-bit blocks. Each block computes both carry hypotheses and selects on the carry
//    registered by the previous stage; one pipeline stage per block.
//  - Valid/ready streaming datapath for the adder/multiplier comparison harness; sustains one operation per clock.
// PARAMETERS
//  WIDTH  16  operand width in bits; must be a multiple of BLK
//  BLK     4  carry-select block width; NBLK = WIDTH/BLK = pipeline depth (min 1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        reset, asynchronous, active-low
//  in_valid   in   1        operand beat offered
//  in_ready   out  1        block can accept a beat this cycle
//  a          in   WIDTH    operand A, unsigned (or two's complement in the ovf sense)
//  b          in   WIDTH    operand B
//  cin        in   1        carry-in; ignored when sub=1
//  sub        in   1        0: a+b+cin; 1: a+~b+1 (a-b)
//  out_valid  out  1        result beat present
//  out_ready  in   1        sink accepts result
//  sum        out  WIDTH+1  {carry_out, result}; sub=1: sum[WIDTH]=1 means no borrow
//  ovf        out  1        signed overflow of the result (present only with macro below)
// BEHAVIOUR
//  - One clock domain (clk). Reset is asynchronous and active-low (rst_n).
//  - Reset (rst_n=0, async): all stage valid bits=0, all stage data/carry regs=0.
//    Outputs: out_valid=0, sum=0, ovf=0, in_ready=0.
//  - Release: in_ready rises combinationally once rst_n=1.
//  - Reset mid-operation: all in-flight beats discarded, no partial result emitted.
//  - Advance enable: adv = ~out_valid | out_ready. in_ready = rst_n & adv.
//  - When adv=1 the whole pipe shifts one stage. When adv=0 every stage register holds. No per-stage skid.
//  - Accept when in_valid & in_ready: stage0 captures all operand fields.
//    - Stage0 resolves block0: s = a[BLK-1:0] + bx[BLK-1:0] + c0, where bx = sub ? ~b : b and c0 = sub ? 1 : cin.
//    - Stage0 stores the partial sum and carry; remaining operand bits travel with the beat.
//  - Stage k (1..NBLK-1):
//    - Precomputes blocks k with cin=0 and cin=1 from the carried operands.
//    - Muxes on stage k-1 registered carry; appends block k to the partial sum and registers the new carry.
//  - Latency: beat accepted on edge E appears with out_valid=1 after edge E+NBLK-1, i.e. NBLK register stages.
//  - Throughput: 1 beat/clk while out_ready=1.
//  - Bubbles: in_valid=0 with adv=1 inserts an invalid stage; data regs may change but are don't-care while invalid.
//  - sum holds stable while out_valid=1 & out_ready=0. No beat lost or duplicated under any backpressure pattern.
//  - Width rules: wrap-around is natural modulo 2^WIDTH in sum[WIDTH-1:0]; sum[WIDTH] = final block carry.
//  - Simultaneous in_valid & out_ready with a full pipe: output retires and input is accepted on the same edge.
// CONFIGURATION
//  - OVERFLOW_FLAG_EN defined:
//    - Port ovf present.
//    - ovf = carry into MSB XOR carry out of MSB, computed in the last stage and registered with sum.
//    - ovf is 0 when out_valid=0.
//  - OVERFLOW_FLAG_EN undefined: port ovf and its logic absent; all other behaviour identical.
// TESTING (WIDTH=16, BLK=4, NBLK=4)
//  1. Reset then a=0x0005,b=0x0003,cin=0,sub=0, out_ready=1 -> out_valid high 4 cycles after accept, sum=0x00008.
//  2. a=0xFFFF,b=0x0001,cin=1,sub=0 -> sum=0x10001 (carry ripples all 4 blocks); with macro, signed operands
//     a=0x7FFF,b=0x0001 -> sum=0x08000, ovf=1.
//  3. sub=1, a=0x000A,b=0x0006 -> sum=0x10004; a=0x0006,b=0x000A -> sum=0x0FFFC (borrow).
//  4. 8 back-to-back beats, out_ready toggled 1,0,0,1,... -> in_ready tracks adv, results in order, none lost or
//     duplicated; sum stable while stalled.
//  5. rst_n pulsed low with 3 beats in flight -> out_valid=0, sum=0 immediately; no stale beat after release.
//  6. Random 10k beats with random in_valid/out_ready vs. reference model a+b+cin / a-b -> zero mismatches.

Source files
------------

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select add/sub: one BLK-bit block resolved per stage, NBLK stages, valid/ready stream.
// Optional signed-overflow output `ovf` is built only when OVERFLOW_FLAG_EN is defined.
module pipelined_carry_select_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef OVERFLOW_FLAG_EN
  output logic             ovf,
`endif
  output logic [WIDTH:0]   sum
);
  localparam int NBLK = WIDTH / BLK;
  localparam int LAST = NBLK - 1;

  logic [NBLK-1:0]  vld_q, vld_d;
  logic [NBLK-1:0]  cy_q, cy_d;
  logic [WIDTH-1:0] a_q    [NBLK];
  logic [WIDTH-1:0] a_d    [NBLK];
  logic [WIDTH-1:0] bx_q   [NBLK];
  logic [WIDTH-1:0] bx_d   [NBLK];
  logic [WIDTH-1:0] psum_q [NBLK];
  logic [WIDTH-1:0] psum_d [NBLK];
`ifdef OVERFLOW_FLAG_EN
  logic [NBLK-1:0]  ov_q, ov_d;
`endif

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic [BLK:0]     s_lo, s_hi, s_sel;

  always_comb begin
    adv    = ~vld_q[LAST] | out_ready;
    bx     = sub ? ~b : b;
    c0     = sub | cin;
    vld_d  = vld_q;
    cy_d   = cy_q;
    a_d    = a_q;
    bx_d   = bx_q;
    psum_d = psum_q;
`ifdef OVERFLOW_FLAG_EN
    ov_d   = ov_q;
`endif
    s_lo   = '0;
    s_hi   = '0;
    s_sel  = '0;
    if (adv) begin
      vld_d[0]  = in_valid;
      a_d[0]    = a;
      bx_d[0]   = bx;
      s_sel     = {1'b0, a[BLK-1:0]} + {1'b0, bx[BLK-1:0]} + {{BLK{1'b0}}, c0};
      psum_d[0] = '0;
      psum_d[0][BLK-1:0] = s_sel[BLK-1:0];
      cy_d[0]   = s_sel[BLK];
`ifdef OVERFLOW_FLAG_EN
      // carry into a block's MSB is a^b^s at that bit; only the last stage's value is used
      ov_d[0]   = a[BLK-1] ^ bx[BLK-1] ^ s_sel[BLK-1] ^ s_sel[BLK];
`endif
      for (int k = 1; k < NBLK; k++) begin
        vld_d[k] = vld_q[k-1];
        a_d[k]   = a_q[k-1];
        bx_d[k]  = bx_q[k-1];
        s_lo     = {1'b0, a_q[k-1][k*BLK +: BLK]} + {1'b0, bx_q[k-1][k*BLK +: BLK]};
        s_hi     = s_lo + (BLK+1)'(1);
        s_sel    = cy_q[k-1] ? s_hi : s_lo;
        psum_d[k] = psum_q[k-1];
        psum_d[k][k*BLK +: BLK] = s_sel[BLK-1:0];
        cy_d[k]  = s_sel[BLK];
`ifdef OVERFLOW_FLAG_EN
        ov_d[k]  = a_q[k-1][k*BLK+BLK-1] ^ bx_q[k-1][k*BLK+BLK-1] ^ s_sel[BLK-1] ^ s_sel[BLK];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
`ifdef OVERFLOW_FLAG_EN
      ov_q  <= '0;
`endif
      for (int k = 0; k < NBLK; k++) begin
        a_q[k]    <= '0;
        bx_q[k]   <= '0;
        psum_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      cy_q   <= cy_d;
`ifdef OVERFLOW_FLAG_EN
      ov_q   <= ov_d;
`endif
      a_q    <= a_d;
      bx_q   <= bx_d;
      psum_q <= psum_d;
    end
  end

  assign in_ready  = rst_n & adv;
  assign out_valid = vld_q[LAST];
  assign sum       = {cy_q[LAST], psum_q[LAST]};
`ifdef OVERFLOW_FLAG_EN
  assign ovf       = ov_q[LAST] & vld_q[LAST];
`endif

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Scoreboard bench for pipelined_carry_select_adder: directed corner beats, backpressure, reset, random traffic.
module tb_pipelined_carry_select_adder;
  localparam int WIDTH = 16;
  localparam int BLK   = 4;
  localparam int NBLK  = WIDTH / BLK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH:0]   sum;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf;
`endif

  typedef struct packed {
    logic [WIDTH:0] sum;
    logic           ovf;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             failures = 0;
  bit             dir_vld = 1'b0;
  logic [WIDTH:0] dir_sum = '0;
  int             ready_mode = 0;
  int             pidx = 0;
  bit             stall_q = 1'b0;
  logic [WIDTH:0] stall_sum = '0;

  always #5 clk = ~clk;

  pipelined_carry_select_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef OVERFLOW_FLAG_EN
    .ovf       (ovf),
`endif
    .sum       (sum)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c, input logic s);
    exp_t   e;
    longint r, sx, sy, sr;
    if (s) r = (longint'(1) << WIDTH) + longint'(x) - longint'(y);
    else   r = longint'(x) + longint'(y) + longint'(c);
    e.sum = r[WIDTH:0];
    sx = x[WIDTH-1] ? longint'(x) - (longint'(1) << WIDTH) : longint'(x);
    sy = y[WIDTH-1] ? longint'(y) - (longint'(1) << WIDTH) : longint'(y);
    sr = s ? sx - sy : sx + sy + longint'(c);
    e.ovf = (sr > ((longint'(1) << (WIDTH-1)) - 1)) || (sr < -(longint'(1) << (WIDTH-1)));
    return e;
  endfunction

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      1:       begin out_ready = (pidx % 4 == 0) || (pidx % 4 == 3); pidx++; end
      2:       out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      check("in_ready_vs_adv", in_ready, !out_valid || out_ready);
      if (stall_q && out_valid) check("sum_stable_stall", sum, stall_sum);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sum", sum, e.sum);
`ifdef OVERFLOW_FLAG_EN
          check("ovf", ovf, e.ovf);
`endif
        end
      end
`ifdef OVERFLOW_FLAG_EN
      if (!out_valid) check("ovf_idle_zero", ovf, 0);
`endif
      stall_q   = out_valid && !out_ready;
      stall_sum = sum;
      if (in_valid && in_ready) begin
        e = model(a, b, cin, sub);
        if (dir_vld) e.sum = dir_sum;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                      input logic s, input bit dir, input logic [WIDTH:0] es);
    bit fire;
    int n = 0;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1; dir_vld = dir; dir_sum = es;
    forever begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk); #1;
      if (fire) break;
      n++;
      if (n > 1000) begin check("accept_timeout", 0, 1); break; end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    dir_vld  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin @(posedge clk); #1; n++; end
    check("drain_empty", sb.size(), 0);
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = '1;
      1:       v = {1'b0, {(WIDTH-1){1'b1}}};
      2:       v = {1'b1, {(WIDTH-1){1'b0}}};
      3:       v = '0;
      default: v = WIDTH'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int lat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_in_ready", in_ready, 0);
`ifdef OVERFLOW_FLAG_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // first beat and latency
    send(16'h0005, 16'h0003, 1'b0, 1'b0, 1'b1, 17'h00008);
    idle();
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency_edges", lat, NBLK - 1);
    drain();

    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 17'h10001);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 17'h08000);
    send(16'h000A, 16'h0006, 1'b0, 1'b1, 1'b1, 17'h10004);
    send(16'h0006, 16'h000A, 1'b1, 1'b1, 1'b1, 17'h0FFFC);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 17'h1FFFF);
    idle();
    drain();

    // back-to-back beats under a 1,0,0,1 out_ready pattern
    pidx = 0;
    ready_mode = 1;
    for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b0, '0);
    idle();
    drain();
    ready_mode = 0;
    @(posedge clk); #1;

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b0, '0);
    rst_n = 1'b0;
    idle();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("no_stale_beat", out_valid, 0);
    end

    // random traffic
    ready_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
      send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b0, '0);
    end
    idle();
    drain();
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
